// File: rtl/glove_window_builder.sv
// Sliding-window frame builder for the recognition core: baseline removal with
// saturation, DEPTH-step window, HOP-paced frame emission and baseline calibration.
module glove_window_builder #(
  parameter int CH       = 8,
  parameter int DEPTH    = 5,
  parameter int HOP      = 1,
  parameter int CAL_LOG2 = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_valid,
  input  logic [CH-1:0][15:0]        i_step,
  input  logic                       i_ready,
  input  logic                       i_cal,
  input  logic                       i_flush,
  output logic                       o_next,
  output logic [CH*DEPTH-1:0][15:0]  o_data,
  output logic                       o_calibrating,
  output logic [15:0]                o_overrun
);

  localparam int FW = $clog2(DEPTH + 1);
  localparam int HW = $clog2(HOP + 1);
  localparam int AW = 16 + CAL_LOG2;
  localparam int CW = CAL_LOG2 + 1;

  typedef enum logic [1:0] {S_FILL, S_RUN, S_CAL} state_t;

  state_t                      state, state_n;
  logic [FW-1:0]               fill, fill_n;
  logic [HW-1:0]               hop, hop_n;
  logic [CW-1:0]               cal_cnt, cal_cnt_n;
  logic [DEPTH-1:0][CH-1:0][15:0] win, win_n;
  logic [CH-1:0][AW-1:0]       acc, acc_n;
  logic [CH-1:0][15:0]         base, base_n;
  logic [CH-1:0][15:0]         step_adj;
  logic                        ovr_inc;
  logic                        emit;

  always_comb begin
    logic signed [16:0] d;
    d = '0;
    step_adj = '0;
    for (int unsigned c = 0; c < CH; c++) begin
      d = $signed({i_step[c][15], i_step[c]}) - $signed({base[c][15], base[c]});
      if (d > 17'sd32767)
        step_adj[c] = 16'h7fff;
      else if (d < -17'sd32768)
        step_adj[c] = 16'h8000;
      else
        step_adj[c] = d[15:0];
    end
  end

  always_comb begin
    state_n   = state;
    fill_n    = fill;
    hop_n     = hop;
    cal_cnt_n = cal_cnt;
    win_n     = win;
    acc_n     = acc;
    base_n    = base;
    ovr_inc   = 1'b0;
    emit      = 1'b0;

    if (i_flush) begin
      state_n   = S_FILL;
      fill_n    = '0;
      hop_n     = '0;
      cal_cnt_n = '0;
    end else if (state == S_CAL || i_cal) begin
      if (state != S_CAL) begin
        state_n   = S_CAL;
        acc_n     = '0;
        cal_cnt_n = '0;
      end
      if (i_valid) begin
        for (int unsigned c = 0; c < CH; c++)
          acc_n[c] = acc_n[c] + AW'($signed(i_step[c]));
        cal_cnt_n = cal_cnt_n + 1'b1;
        if (cal_cnt_n == CW'(2 ** CAL_LOG2)) begin
          for (int unsigned c = 0; c < CH; c++)
            base_n[c] = 16'($signed(acc_n[c]) >>> CAL_LOG2);
          state_n   = S_FILL;
          fill_n    = '0;
          hop_n     = '0;
          cal_cnt_n = '0;
        end
      end
    end else if (i_valid) begin
      // Kept as a shift register so index 0 is always the oldest step;
      // observably identical to a circular buffer read out oldest-first.
      win_n = {step_adj, win[DEPTH-1:1]};
      if (fill != FW'(DEPTH))
        fill_n = fill + 1'b1;
      if (fill_n == FW'(DEPTH))
        state_n = S_RUN;
      // Overrun only counts while a full window is waiting on i_ready.
      if (hop == HW'(HOP))
        ovr_inc = (state == S_RUN);
      else
        hop_n = hop + 1'b1;
    end

    emit = (state_n == S_RUN) && (hop_n >= HW'(HOP)) && i_ready;
    if (emit)
      hop_n = '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= S_FILL;
      fill      <= '0;
      hop       <= '0;
      cal_cnt   <= '0;
      win       <= '0;
      acc       <= '0;
      base      <= '0;
      o_next    <= 1'b0;
      o_data    <= '0;
      o_overrun <= '0;
    end else begin
      state   <= state_n;
      fill    <= fill_n;
      hop     <= hop_n;
      cal_cnt <= cal_cnt_n;
      win     <= win_n;
      acc     <= acc_n;
      base    <= base_n;
      o_next  <= emit;
      if (emit)
        o_data <= win_n;
      if (ovr_inc && o_overrun != '1)
        o_overrun <= o_overrun + 1'b1;
    end
  end

  assign o_calibrating = (state == S_CAL);

endmodule

// File: tb/tb_glove_window_builder.sv
// Directed bench for glove_window_builder: a behavioural model pushes expected
// frames to a scoreboard queue, a negedge monitor pops and compares on o_next.
module tb_glove_window_builder;

  typedef logic [39:0][15:0] frame_t;

  logic              i_clk = 1'b0;
  logic              i_rst_n;
  logic              i_valid;
  logic [7:0][15:0]  i_step;
  logic              i_ready;
  logic              i_cal;
  logic              i_flush;
  logic              o_next;
  frame_t            o_data;
  logic              o_calibrating;
  logic [15:0]       o_overrun;

  glove_window_builder #(.CH(8), .DEPTH(5), .HOP(1), .CAL_LOG2(4)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_step(i_step),
    .i_ready(i_ready), .i_cal(i_cal), .i_flush(i_flush), .o_next(o_next),
    .o_data(o_data), .o_calibrating(o_calibrating), .o_overrun(o_overrun)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;
  int nnext  = 0;
  frame_t q[$];

  // reference model state: mst 0=fill 1=run 2=cal
  int sv[8];
  int mwin[5][8];
  int mbase[8];
  int macc[8];
  int mst = 0, mfill = 0, mhop = 0, mcnt = 0, movr = 0;

  function automatic int sat(input int x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  task automatic model_edge(input bit valid, input bit cal, input bit flush, input bit rdy);
    frame_t f;
    if (flush) begin
      mst = 0; mfill = 0; mhop = 0; mcnt = 0;
    end else if (mst == 2 || cal) begin
      if (mst != 2) begin
        mst = 2; mcnt = 0;
        for (int c = 0; c < 8; c++) macc[c] = 0;
      end
      if (valid) begin
        for (int c = 0; c < 8; c++) macc[c] += sv[c];
        mcnt++;
        if (mcnt == 16) begin
          for (int c = 0; c < 8; c++) mbase[c] = macc[c] >>> 4;
          mst = 0; mfill = 0; mhop = 0; mcnt = 0;
        end
      end
    end else if (valid) begin
      for (int t = 0; t < 4; t++)
        for (int c = 0; c < 8; c++) mwin[t][c] = mwin[t+1][c];
      for (int c = 0; c < 8; c++) mwin[4][c] = sat(sv[c] - mbase[c]);
      if (mhop == 1) begin
        if (mst == 1 && movr < 65535) movr++;
      end else mhop++;
      if (mfill < 5) mfill++;
      if (mfill == 5) mst = 1;
    end
    if (mst == 1 && mhop >= 1 && rdy) begin
      for (int t = 0; t < 5; t++)
        for (int c = 0; c < 8; c++) f[t*8+c] = 16'(mwin[t][c]);
      q.push_back(f);
      mhop = 0;
    end
  endtask

  task automatic tick(input bit valid, input bit cal, input bit flush, input bit rdy);
    i_valid = valid; i_cal = cal; i_flush = flush; i_ready = rdy;
    for (int c = 0; c < 8; c++) i_step[c] = 16'(sv[c]);
    model_edge(valid, cal, flush, rdy);
    @(posedge i_clk);
    #1;
    i_valid = 1'b0; i_cal = 1'b0; i_flush = 1'b0;
  endtask

  task automatic fill_sv(input int v);
    for (int c = 0; c < 8; c++) sv[c] = v;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Emission lands at the negedge right after the accepting edge.
  task automatic drain(input string tag);
    @(negedge i_clk);
    #1;
    chk(tag, 16'(q.size()), 16'd0);
  endtask

  always @(negedge i_clk) begin
    if (i_rst_n && o_next) begin
      frame_t e;
      nnext++;
      checks++;
      assert (q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_next observed=1 expected=0");
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        checks++;
        assert (o_data === e) else begin
          errors++;
          $error("FAIL frame observed=%h expected=%h", o_data, e);
        end
      end
    end
  end

  initial begin
    int n0;
    i_rst_n = 1'b0; i_valid = 1'b0; i_cal = 1'b0; i_flush = 1'b0; i_ready = 1'b1;
    i_step = '0;
    for (int c = 0; c < 8; c++) begin mbase[c] = 0; macc[c] = 0; end
    for (int t = 0; t < 5; t++) for (int c = 0; c < 8; c++) mwin[t][c] = 0;
    #12;
    chk("rst_next", 16'(o_next), 16'd0);
    chk("rst_data_or", 16'(|o_data), 16'd0);
    chk("rst_cal", 16'(o_calibrating), 16'd0);
    chk("rst_ovr", o_overrun, 16'd0);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    // 1: first window
    n0 = nnext;
    for (int s = 0; s < 5; s++) begin
      for (int c = 0; c < 8; c++) sv[c] = s*16 + c;
      tick(1, 0, 0, 1);
    end
    drain("t1_drain");
    chk("t1_count", 16'(nnext - n0), 16'd1);
    chk("t1_d0", o_data[0], 16'd0);
    chk("t1_d7", o_data[7], 16'd7);
    chk("t1_d39", o_data[39], 16'd71);

    // 2: hop of one
    for (int c = 0; c < 8; c++) sv[c] = 5*16 + c;
    tick(1, 0, 0, 1);
    drain("t2_drain");
    chk("t2_d0", o_data[0], 16'd16);
    chk("t2_d39", o_data[39], 16'd87);

    // 3: blocked emission
    n0 = nnext;
    for (int s = 6; s < 9; s++) begin
      for (int c = 0; c < 8; c++) sv[c] = s*16 + c;
      tick(1, 0, 0, 0);
    end
    tick(0, 0, 0, 1);
    drain("t3_drain");
    chk("t3_count", 16'(nnext - n0), 16'd1);
    chk("t3_d0", o_data[0], 16'd64);
    chk("t3_d39", o_data[39], 16'd135);
    chk("t3_ovr", o_overrun, 16'(movr));
    chk("t3_ovr_const", o_overrun, 16'd2);

    // 4: calibrate on 1000, then saturation low
    tick(0, 1, 0, 1);
    chk("t4_cal_on", 16'(o_calibrating), 16'd1);
    fill_sv(1000);
    for (int i = 0; i < 16; i++) begin
      tick(1, 0, 0, 1);
      chk("t4_cal_flag", 16'(o_calibrating), (i < 15) ? 16'd1 : 16'd0);
    end
    fill_sv(500);
    for (int i = 0; i < 5; i++) tick(1, 0, 0, 1);
    drain("t4_drain");
    chk("t4_d0", o_data[0], 16'(-500));
    chk("t4_d39", o_data[39], 16'(-500));
    fill_sv(-32768);
    tick(1, 0, 0, 1);
    drain("t4_sat_drain");
    chk("t4_sat39", o_data[39], 16'h8000);
    chk("t4_sat32", o_data[32], 16'h8000);
    chk("t4_d31", o_data[31], 16'(-500));

    // 5: calibrate on -1000, saturation high; then floor baseline
    tick(0, 1, 0, 1);
    fill_sv(-1000);
    for (int i = 0; i < 16; i++) tick(1, 0, 0, 1);
    fill_sv(32767);
    for (int i = 0; i < 5; i++) tick(1, 0, 0, 1);
    drain("t5_drain");
    chk("t5_sat39", o_data[39], 16'h7fff);
    tick(0, 1, 0, 1);
    for (int i = 0; i < 16; i++) begin
      fill_sv((i % 2 == 0) ? -1 : 0);
      tick(1, 0, 0, 1);
    end
    fill_sv(0);
    for (int i = 0; i < 5; i++) tick(1, 0, 0, 1);
    drain("t5_floor_drain");
    chk("t5_floor", o_data[20], 16'd1);

    // 6: flush restarts fill
    fill_sv(7);
    tick(0, 0, 1, 1);
    for (int i = 0; i < 3; i++) tick(1, 0, 0, 1);
    tick(0, 0, 1, 1);
    n0 = nnext;
    for (int i = 0; i < 4; i++) tick(1, 0, 0, 1);
    @(negedge i_clk); #1;
    chk("t6_no_next", 16'(nnext - n0), 16'd0);
    tick(1, 0, 0, 1);
    drain("t6_drain");
    chk("t6_next", 16'(nnext - n0), 16'd1);
    chk("t6_ovr_kept", o_overrun, 16'd2);

    // async reset while o_next is high
    fill_sv(9);
    tick(1, 0, 0, 1);
    chk("t6_pre_rst_next", 16'(o_next), 16'd1);
    i_rst_n = 1'b0;
    #1;
    q.delete();
    chk("t6_rst_next", 16'(o_next), 16'd0);
    chk("t6_rst_data", 16'(|o_data), 16'd0);
    chk("t6_rst_ovr", o_overrun, 16'd0);
    #10;
    i_rst_n = 1'b1;
    #10;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/glove_window_builder.md
Name: glove_window_builder

Overview:
- Upstream feeder of the recognition core.
- Accepts one glove sensor time step per valid cycle and keeps a sliding window of the most recent DEPTH steps.
- Removes a per-channel calibrated baseline, with saturation.
- Presents the window as the 40-word signed frame the core consumes and pulses o_next to launch one core inference.

Parameters:
- CH, 8, sensor channels per time step.
- DEPTH, 5, time steps per window (CH*DEPTH must equal 40).
- HOP, 1, new time steps required between successive emissions.
- CAL_LOG2, 4, log2 of the number of steps averaged for the baseline.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  a time step is presented; always accepted, no backpressure.
- i_step  in  16 x CH signed  raw channel samples, index = channel.
- i_ready  in  1  core can take a new frame; emission only while high.
- i_cal  in  1  one-cycle pulse, start baseline calibration.
- i_flush  in  1  one-cycle pulse, discard window fill state.
- o_next  out  1  one-cycle pulse, o_data holds a new frame.
- o_data  out  16 x 40 signed  frame, o_data[t*CH+c], t=0 oldest step, t=DEPTH-1 newest.
- o_calibrating  out  1  high while in S_CAL.
- o_overrun  out  16  count of steps skipped while an emission was blocked; saturates at 65535.

Behaviour:
- Reset (async, i_rst_n low): o_next=0, o_data all 0, o_calibrating=0, o_overrun=0, baseline all 0, fill count 0, hop count 0, state S_FILL. Effect is immediate, not clock-gated.
- States: S_FILL (fewer than DEPTH steps held), S_RUN (window full), S_CAL (accumulating baseline).
- Accepted step (S_FILL/S_RUN):
  - Each channel stored as sat16(i_step[c] - baseline[c]). The subtraction is computed at 17 bits and clamped to [-32768, 32767].
  - The step is pushed into a circular buffer of DEPTH entries, overwriting the oldest.
  - Fill count increments, saturating at DEPTH; S_FILL moves to S_RUN when it reaches DEPTH.
  - Hop count increments, saturating at HOP. If hop count was already HOP before the increment, o_overrun increments.
- Emission condition, evaluated every cycle using next-state values:
  - Requires state S_RUN (next-state), hop count >= HOP, and i_ready=1.
  - When true: on the next edge o_next=1 and o_data takes the window in oldest-to-newest order, including any step accepted that same cycle. Hop count clears to 0.
  - Latency: step accepted at edge k gives o_next high in the cycle after edge k, when i_ready is high.
  - When false, o_next returns to 0 and o_data is held unchanged.
  - The first emission after reset or flush requires DEPTH steps. Later emissions require HOP new steps.
- Blocked emission (i_ready low): pending state is implicit in the hop count. Steps keep entering the window. Emission occurs on the first cycle i_ready is high and carries the newest DEPTH steps. Only one o_next is issued however many steps arrived.
- i_cal in S_FILL/S_RUN:
  - Go to S_CAL and clear the accumulator (width 16+CAL_LOG2 per channel, signed).
  - In S_CAL, accepted steps add raw i_step into the accumulator. They are not written to the window and no emission occurs.
  - After 2^CAL_LOG2 steps: baseline[c] = accumulator[c] >>> CAL_LOG2 (arithmetic shift, rounds toward minus infinity). Then go to S_FILL with fill and hop counts cleared.
- i_cal while in S_CAL: ignored.
- i_flush: fill, hop and calibration counters clear and state goes to S_FILL. Baseline, o_data and o_overrun are kept. A flush during S_CAL aborts the calibration and leaves the baseline unchanged.
- i_flush and i_cal in the same cycle: flush wins.
- i_flush and i_valid in the same cycle: the step is discarded.
- i_cal and i_valid in the same cycle: the step is the first calibration sample.

Test Plan:
1. Reset, i_ready=1, feed steps s=0..4 with value s*16+c → o_next pulses exactly once, in the cycle after step 4. o_data[0]=0, o_data[7]=7, o_data[39]=71.
2. Continue with step 5 → o_next pulses one cycle later. o_data[0]=16, o_data[39]=87.
3. Drop i_ready during steps 6,7,8, raise it after step 8 → a single o_next. o_data[0]=64 (step 4), o_data[39]=135. o_overrun=2.
4. Pulse i_cal, feed 16 steps of all 1000 → o_calibrating high for 16 steps and baseline=1000. Then 5 steps of 500 → o_data all -500. Then a step of -32768 → newest words saturate to -32768.
5. Calibrate on all -1000, then feed 32767 → output saturates at 32767. Calibrate on alternating -1 and 0 → baseline -1 (floor).
6. After 3 steps pulse i_flush → no o_next until 5 further steps. Assert i_rst_n low mid-run → o_next, o_data, o_overrun read 0 before the next clock edge.
